// File: rtl/iir_pkg.sv
// Shared definitions for the iir filter datapath and its downstream blocks.
package iir_pkg;
  localparam int IIR_DW = 13;
  typedef logic signed [IIR_DW-1:0] iir_sample_t;
endpackage

// File: rtl/iir_out_buffer_if.sv
// Bundle of the sample-in / sample-out / status signals of iir_out_buffer.
// Handshake: the producer side (VIN/DIN) has no backpressure; on the consumer
// side a sample transfers at every rising edge where VOUT & RDY are both 1.
interface iir_out_buffer_if #(
  parameter int DW    = iir_pkg::IIR_DW,
  parameter int DEPTH = 8,
  parameter int CW    = 8
);
  logic                   VIN;
  logic [DW-1:0]          DIN;
  logic                   VOUT;
  logic [DW-1:0]          DOUT;
  logic                   RDY;
  logic                   FULL;
  logic [$clog2(DEPTH):0] LEVEL;
  logic                   OVF;
  logic [CW-1:0]          DROPS;
  logic                   CLR_OVF;

  modport master (
    output VIN, DIN, RDY, CLR_OVF,
    input  VOUT, DOUT, FULL, LEVEL, OVF, DROPS
  );

  modport slave (
    input  VIN, DIN, RDY, CLR_OVF,
    output VOUT, DOUT, FULL, LEVEL, OVF, DROPS
  );
endinterface

// File: rtl/iir_buf_ram.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module iir_buf_ram #(
  parameter int DW    = 13,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/iir_out_buffer.sv
// First-word-fall-through FIFO behind the iir filter; samples that arrive while
// full and not draining are dropped and counted in a sticky, saturating counter.
module iir_out_buffer
  import iir_pkg::*;
#(
  parameter int DW    = IIR_DW,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input logic              CLK,
  input logic              RST,
  iir_out_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] drops_q, drops_d;
  logic          full, vout, push, pop, drop;

  assign full = (level_q == LW'(DEPTH));
  assign vout = (level_q != '0);
  assign pop  = vout & bus.RDY;
  // A pop on the same edge frees a slot, so a full buffer still accepts VIN.
  assign push = bus.VIN & (~full | pop);
  assign drop = bus.VIN & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drops_d  = drops_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A drop on the clearing edge restarts the count at one rather than zero.
    if (drop) begin
      ovf_d = 1'b1;
      if (bus.CLR_OVF)         drops_d = CW'(1);
      else if (drops_q != '1)  drops_d = drops_q + CW'(1);
    end else if (bus.CLR_OVF) begin
      ovf_d   = 1'b0;
      drops_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
    end
  end

  iir_buf_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.DIN),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.DOUT)
  );

  assign bus.VOUT  = vout;
  assign bus.FULL  = full;
  assign bus.LEVEL = level_q;
  assign bus.OVF   = ovf_q;
  assign bus.DROPS = drops_q;
endmodule

// File: tb/tb_iir_out_buffer.sv
// Bench for iir_out_buffer: directed scenarios plus random traffic, compared
// every cycle against a queue model of the buffer.
module tb_iir_out_buffer;
  import iir_pkg::*;

  localparam int DW    = IIR_DW;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int DMAX  = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  iir_out_buffer_if #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) bus ();
  iir_out_buffer_if #(.DW(DW), .DEPTH(DEPTH), .CW(2))  bus2 ();

  iir_out_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  iir_out_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(2))  dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  bit m_ovf   = 1'b0;
  int m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: the FIFO as a queue, updated from the inputs seen at each edge.
  always @(posedge CLK) begin : model
    bit m_full, m_pop, m_drop;
    if (RST) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      m_pop  = (exp_q.size() != 0) && bus.RDY;
      m_drop = bus.VIN && m_full && !m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (bus.VIN && !m_drop) exp_q.push_back(bus.DIN);
      if (m_drop) begin
        m_ovf   = 1'b1;
        m_drops = bus.CLR_OVF ? 1 : ((m_drops < DMAX) ? m_drops + 1 : DMAX);
      end else if (bus.CLR_OVF) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cyc_vout",  32'(bus.VOUT),  32'(exp_q.size() != 0));
      check("cyc_full",  32'(bus.FULL),  32'(exp_q.size() == DEPTH));
      check("cyc_level", 32'(bus.LEVEL), 32'(exp_q.size()));
      check("cyc_ovf",   32'(bus.OVF),   32'(m_ovf));
      check("cyc_drops", 32'(bus.DROPS), 32'(m_drops));
      if (exp_q.size() != 0) check("cyc_dout", 32'(bus.DOUT), 32'(exp_q[0]));
    end
  end

  logic [DW-1:0] vals [8];
  int rdy_pct;

  function automatic logic [DW-1:0] ov(input int k);
    return DW'(k * 300 + 17);
  endfunction

  initial begin
    bus.VIN = 1'b0; bus.DIN = '0; bus.RDY = 1'b0; bus.CLR_OVF = 1'b0;
    bus2.VIN = 1'b0; bus2.DIN = '0; bus2.RDY = 1'b0; bus2.CLR_OVF = 1'b0;
    vals[0] = 13'h1000; vals[1] = 13'h0FFF; vals[2] = 13'h0001; vals[3] = 13'h1FFF;
    vals[4] = 13'h0064; vals[5] = 13'h1F9C; vals[6] = 13'h0AAA; vals[7] = 13'h1555;

    // Reset then idle
    RST = 1'b1;
    tick; tick;
    RST = 1'b0;
    cmp_en = 1'b1;
    check("rst_vout",  32'(bus.VOUT),  0);
    check("rst_level", 32'(bus.LEVEL), 0);
    check("rst_full",  32'(bus.FULL),  0);
    check("rst_ovf",   32'(bus.OVF),   0);
    check("rst_drops", 32'(bus.DROPS), 0);
    repeat (10) tick;
    check("idle_vout",  32'(bus.VOUT),  0);
    check("idle_level", 32'(bus.LEVEL), 0);

    // Streaming with RDY held high
    bus.RDY = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      bus.VIN = 1'b1; bus.DIN = DW'(i);
      tick;
      check("stream_dout",  32'(bus.DOUT), 32'(i));
      check("stream_vout",  32'(bus.VOUT), 1);
      check("stream_level", 32'(bus.LEVEL <= 1), 1);
    end
    bus.VIN = 1'b0;
    tick;
    check("stream_end_vout", 32'(bus.VOUT), 0);
    check("stream_ovf",      32'(bus.OVF),  0);

    // Fill and drain
    bus.RDY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.VIN = 1'b1; bus.DIN = vals[k];
      tick;
    end
    bus.VIN = 1'b0;
    check("fill_full",  32'(bus.FULL),  1);
    check("fill_level", 32'(bus.LEVEL), 8);
    bus.RDY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_dout", 32'(bus.DOUT), 32'(vals[k]));
      tick;
    end
    check("drain_vout", 32'(bus.VOUT), 0);
    bus.RDY = 1'b0;

    // Overflow: 11 pushes into 8 slots
    for (int k = 0; k < 11; k++) begin
      bus.VIN = 1'b1; bus.DIN = ov(k);
      tick;
    end
    bus.VIN = 1'b0;
    check("ovf_flag",  32'(bus.OVF),   1);
    check("ovf_drops", 32'(bus.DROPS), 3);
    check("ovf_level", 32'(bus.LEVEL), 8);
    bus.CLR_OVF = 1'b1;
    tick;
    bus.CLR_OVF = 1'b0;
    check("clr_ovf",   32'(bus.OVF),   0);
    check("clr_drops", 32'(bus.DROPS), 0);
    check("clr_head",  32'(bus.DOUT),  32'(ov(0)));

    // Full with simultaneous push and pop
    bus.VIN = 1'b1; bus.DIN = 13'h0ABC; bus.RDY = 1'b1;
    tick;
    bus.VIN = 1'b0; bus.RDY = 1'b0;
    check("pp_level", 32'(bus.LEVEL), 8);
    check("pp_drops", 32'(bus.DROPS), 0);
    check("pp_head",  32'(bus.DOUT),  32'(ov(1)));

    // Clear together with a drop
    bus.VIN = 1'b1; bus.DIN = 13'h0005; bus.CLR_OVF = 1'b1;
    tick;
    bus.VIN = 1'b0; bus.CLR_OVF = 1'b0;
    check("clrdrop_ovf",   32'(bus.OVF),   1);
    check("clrdrop_drops", 32'(bus.DROPS), 1);
    bus.RDY = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check("pp_drain", 32'(bus.DOUT), 32'(ov(k)));
      tick;
    end
    check("pp_last", 32'(bus.DOUT), 32'h0ABC);
    tick;
    check("pp_empty", 32'(bus.VOUT), 0);
    bus.RDY = 1'b0;

    // Mid-operation reset
    for (int k = 0; k < 5; k++) begin
      bus.VIN = 1'b1; bus.DIN = DW'(k + 40);
      tick;
    end
    check("mid_level", 32'(bus.LEVEL), 5);
    RST = 1'b1; bus.VIN = 1'b1; bus.DIN = 13'h0777;
    tick;
    RST = 1'b0; bus.VIN = 1'b0;
    check("mid_rst_level", 32'(bus.LEVEL), 0);
    check("mid_rst_vout",  32'(bus.VOUT),  0);
    check("mid_rst_full",  32'(bus.FULL),  0);
    check("mid_rst_ovf",   32'(bus.OVF),   0);
    check("mid_rst_drops", 32'(bus.DROPS), 0);
    tick;
    check("mid_rst_lost", 32'(bus.VOUT), 0);

    // Saturation on the 2-bit drop counter
    for (int k = 0; k < 13; k++) begin
      bus2.VIN = 1'b1; bus2.DIN = DW'(k);
      tick;
    end
    bus2.VIN = 1'b0;
    check("sat_drops", 32'(bus2.DROPS), 3);
    check("sat_ovf",   32'(bus2.OVF),   1);
    check("sat_full",  32'(bus2.FULL),  1);

    // Random traffic
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = $urandom_range(5, 95);
      bus.VIN     = 1'($urandom_range(0, 1));
      bus.DIN     = DW'($urandom_range(0, 8191));
      bus.RDY     = ($urandom_range(0, 99) < rdy_pct);
      bus.CLR_OVF = ($urandom_range(0, 31) == 0);
      RST         = ($urandom_range(0, 499) == 0);
      tick;
    end
    RST = 1'b0; bus.VIN = 1'b0; bus.RDY = 1'b0; bus.CLR_OVF = 1'b0;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Output buffer sitting directly downstream of the `iir` filter: it captures every 13-bit sample the filter emits on its VIN/DIN-style strobe and presents them to the consumer (data sink, DMA or serializer) through a valid/ready handshake. The `iir` output has no backpressure, so this block absorbs consumer stalls in a small FIFO and reports any lost samples via a sticky overflow flag and a drop counter.

## Interface
Parameters:
- `DW`, 13, sample width (matches the `iir` DOUT width)
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `CW`, 8, drop-counter width

Ports:
- `CLK`  in  1  clock
- `RST`  in  1  synchronous, active-high reset
- `VIN`  in  1  sample strobe from `iir` VOUT
- `DIN`  in  DW  sample from `iir` DOUT, two's complement
- `VOUT`  out  1  head sample valid (= not empty)
- `DOUT`  out  DW  head sample
- `RDY`  in  1  consumer ready; transfer when VOUT & RDY at a rising edge
- `FULL`  out  1  DEPTH entries held
- `LEVEL`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `OVF`  out  1  sticky: at least one sample dropped
- `DROPS`  out  CW  dropped-sample count, saturating at 2^CW−1
- `CLR_OVF`  in  1  clears OVF and DROPS

## Operation
- push = VIN & (!FULL | pop); pop = VOUT & RDY. Both evaluated at the same edge.
- Write: on push, mem[wr_ptr] ← DIN, wr_ptr++ mod DEPTH.
- Read: first-word-fall-through; DOUT = mem[rd_ptr] combinationally; on pop, rd_ptr++ mod DEPTH.
- LEVEL: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full and VIN with pop: push accepted (slot freed the same edge), no drop, LEVEL stays DEPTH.
- Full and VIN without pop: sample discarded, memory/pointers unchanged, OVF ← 1, DROPS ← DROPS+1 saturating.
- Empty and VIN: no bypass; sample stored; VOUT rises the next cycle.
- CLR_OVF: OVF ← 0, DROPS ← 0; if a drop occurs on the same edge, the drop wins: OVF = 1, DROPS = 1.
- DOUT is don't-care while VOUT = 0; the bench must not check it.
- No data arithmetic; samples pass bit-exact.

## Timing
- Reset (RST = 1 at an edge): wr_ptr = rd_ptr = 0, LEVEL = 0, VOUT = 0, FULL = 0, OVF = 0, DROPS = 0. Memory contents are not reset.
- RST dominates every other input on the same edge. Samples in flight are lost, and no drop is counted.
- Latency: a sample pushed at edge k appears on DOUT/VOUT after edge k and can be popped at edge k+1.
- Throughput: one push and one pop per cycle sustained; with RDY held at 1, LEVEL never exceeds 1.
- FULL, VOUT, LEVEL, OVF and DROPS are registered-state-derived; no combinational path from VIN or DIN to any output. The only input-to-output combinational path is none: pop affects state only.
- Occupancy is tracked by the LEVEL counter, not by pointer comparison.

## Structure
- Shared package `iir_pkg`: `IIR_DW = 13`, typedef `iir_sample_t` (signed [IIR_DW-1:0]). The buffer defaults `DW` to `IIR_DW`.
- Sub-module `iir_buf_ram`: DEPTH×DW register array, one synchronous write port, one asynchronous read port, no reset. Pointer, level, overflow and drop logic stay in `iir_out_buffer`.

## Test plan
- Reset then idle: after RST, VOUT = 0, LEVEL = 0, FULL = 0, OVF = 0, DROPS = 0; 10 idle cycles with no change.
- Streaming: RDY = 1, VIN every cycle with DIN = 0, 1, …, 20. Expect DOUT = the same sequence, one cycle delayed, with LEVEL ≤ 1 and OVF = 0.
- Fill and drain: RDY = 0, push −4096, 4095, and 6 more values. Expect FULL = 1, LEVEL = 8. Then set RDY = 1 with no VIN; expect the 8 values out in order, then VOUT = 0.
- Overflow: RDY = 0, push 11 samples. Expect the first 8 kept, OVF = 1, DROPS = 3. Pulse CLR_OVF alone; expect OVF = 0, DROPS = 0, and stored data intact.
- Full with simultaneous push and pop: FIFO full, VIN = 1 and RDY = 1 on the same edge. Expect no drop, LEVEL = 8, and the new sample emerging 8th in order. Also: CLR_OVF together with a drop gives DROPS = 1, OVF = 1.
- Mid-operation reset and saturation: with LEVEL = 5, assert RST with VIN = 1; expect everything at reset values. Then, with CW = 2, force 5 drops; expect DROPS = 3 (saturated).
